// File: rtl/tinker_mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tinker_arb_pkg                                         |
// | Description : Shared types and constants for the Tinker memory       |
// |               arbiter (FSM states, grant encoding, latency limit).   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package tinker_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } arb_grant_t;

  // Largest memory latency the 3-bit wait counter can sequence.
  localparam int ARB_MAX_LATENCY = 7;

endpackage
`default_nettype wire

// File: rtl/tinker_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tinker_mem_arbiter_if                                  |
// | Description : Bundles the fetch port, data port and memory port of   |
// |               the Tinker memory arbiter.                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface tinker_mem_arbiter_if #(
  parameter int ADDR_W = 64
);

  // Instruction-fetch requester
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;

  // Load/store requester
  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_we;
  logic [ADDR_W-1:0] d_addr;
  logic [63:0]       d_wdata;
  logic              d_rsp_valid;
  logic [63:0]       d_rsp_data;

  // Single-port memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  // Arbiter side: takes requests and memory read data, drives the rest.
  modport slave (
    input  if_req_valid, if_addr,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_valid, d_req_we, d_addr, d_wdata,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Environment side: the core requesters plus the memory unit.
  modport master (
    output if_req_valid, if_addr,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_valid, d_req_we, d_addr, d_wdata,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface
`default_nettype wire

// File: rtl/tinker_mem_arbiter_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tinker_rr_arb2                                         |
// | Description : Two-input round-robin picker. Bit 0 is fetch, bit 1 is |
// |               data. Purely combinational; history lives in parent.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tinker_rr_arb2
  import tinker_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_grant_t last_grant,
  input  logic       en,
  output logic [1:0] gnt
);

  // A lone requester wins; on a tie the side not served last time wins.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || (last_grant == DATA))) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        gnt = 2'b10;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tinker_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tinker_mem_arbiter                                     |
// | Description : Shares the single-port Tinker memory between fetch and |
// |               load/store. One transaction in flight, round-robin on  |
// |               conflicts, fixed read latency MEM_LATENCY.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tinker_mem_arbiter
  import tinker_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 0,
  parameter int ADDR_W      = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  tinker_mem_arbiter_if.slave  bus
);

  // Latency limited to what the 3-bit counter can express.
  localparam int c_lat = (MEM_LATENCY > ARB_MAX_LATENCY) ? ARB_MAX_LATENCY :
                         ((MEM_LATENCY < 0) ? 0 : MEM_LATENCY);
  localparam logic [2:0] c_lat_load = (c_lat > 0) ? 3'(c_lat - 1) : 3'd0;

  arb_state_t        r_state;
  arb_grant_t        r_last_grant;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [63:0]       r_wdata;
  logic              r_mem_en;
  logic              r_mem_we;
  logic              r_if_rsp_valid;
  logic [31:0]       r_if_rsp_data;
  logic              r_d_rsp_valid;
  logic [63:0]       r_d_rsp_data;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_arb_en;
  logic              w_accept;
  logic              w_capture;

  assign w_req    = {bus.d_req_valid, bus.if_req_valid};
  // Ready is only offered from IDLE, and never while reset is held.
  assign w_arb_en = (r_state == IDLE) && !reset;

  tinker_rr_arb2 u_rr_arb2 (
    .req        (w_req),
    .last_grant (r_last_grant),
    .en         (w_arb_en),
    .gnt        (w_gnt)
  );

  assign w_accept  = |w_gnt;
  // Read data is sampled at the end of ISSUE (zero latency) or at the
  // last WAIT cycle.
  assign w_capture = ((r_state == ISSUE) && (c_lat == 0)) ||
                     ((r_state == WAIT) && (r_cnt == 3'd0));

  // Transaction sequencer: accept, issue, wait out latency, respond.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_last_grant   <= DATA;
      r_cnt          <= 3'd0;
      r_addr         <= '0;
      r_we           <= 1'b0;
      r_wdata        <= 64'd0;
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_if_rsp_valid <= 1'b0;
      r_if_rsp_data  <= 32'd0;
      r_d_rsp_valid  <= 1'b0;
      r_d_rsp_data   <= 64'd0;
    end else begin
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_if_rsp_valid <= 1'b0;
      r_d_rsp_valid  <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_gnt[1] ? DATA : FETCH;
            r_addr       <= w_gnt[1] ? bus.d_addr : bus.if_addr;
            r_we         <= w_gnt[1] & bus.d_req_we;
            r_wdata      <= w_gnt[1] ? bus.d_wdata : 64'd0;
            r_mem_en     <= 1'b1;
            r_mem_we     <= w_gnt[1] & bus.d_req_we;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (c_lat == 0) begin
            r_state <= RESP;
          end else begin
            r_cnt   <= c_lat_load;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase

      // Capture into the response registers so the response cycle sees
      // only flopped data.
      if (w_capture) begin
        if (r_last_grant == FETCH) begin
          r_if_rsp_valid <= 1'b1;
          r_if_rsp_data  <= bus.mem_rdata[31:0];
        end else begin
          r_d_rsp_valid <= 1'b1;
          r_d_rsp_data  <= r_we ? 64'd0 : bus.mem_rdata;
        end
      end
    end
  end

  assign bus.if_req_ready = w_gnt[0];
  assign bus.d_req_ready  = w_gnt[1];
  assign bus.if_rsp_valid = r_if_rsp_valid;
  assign bus.if_rsp_data  = r_if_rsp_data;
  assign bus.d_rsp_valid  = r_d_rsp_valid;
  assign bus.d_rsp_data   = r_d_rsp_data;
  assign bus.mem_en       = r_mem_en;
  assign bus.mem_we       = r_mem_we;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_wdata    = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_tinker_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_tinker_mem_arbiter                                  |
// | Description : Self-checking bench. dut0 runs MEM_LATENCY=0, dut1 runs |
// |               MEM_LATENCY=3. Expected responses are queued on accept |
// |               and compared against observed responses.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_tinker_mem_arbiter;

  localparam int ADDR_W = 64;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tinker_mem_arbiter_if #(.ADDR_W(ADDR_W)) b0 ();
  tinker_mem_arbiter_if #(.ADDR_W(ADDR_W)) b1 ();

  tinker_mem_arbiter #(.MEM_LATENCY(0), .ADDR_W(ADDR_W)) dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (b0)
  );

  tinker_mem_arbiter #(.MEM_LATENCY(3), .ADDR_W(ADDR_W)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (b1)
  );

  // dut0 memory: fixed contents; 0x2000 holds the known instruction word.
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    if (a == 64'h2000) return 64'h0000_0000_C840_0004;
    return {~a[31:0], a[31:0] ^ 32'h5A5A_1234};
  endfunction

  assign b0.mem_rdata = mem_word(b0.mem_addr);
  // dut1 memory: data changes every cycle, so the sampling cycle is visible.
  assign b1.mem_rdata = {b1.mem_addr[31:0], 32'(cyc)};

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } rec_t;

  rec_t exp_f0[$], obs_f0[$], exp_d0[$], obs_d0[$];
  rec_t exp_f1[$], obs_f1[$], exp_d1[$], obs_d1[$];
  logic [63:0] w0;

  // Scoreboard feed: expectation on accept, observation on response.
  always @(negedge clk) begin
    if (!rst0) begin
      if (b0.if_req_valid && b0.if_req_ready) begin
        w0 = mem_word(b0.if_addr);
        exp_f0.push_back('{data: {32'h0, w0[31:0]}, cyc: cyc + 2});
      end
      if (b0.d_req_valid && b0.d_req_ready)
        exp_d0.push_back('{data: (b0.d_req_we ? 64'h0 : mem_word(b0.d_addr)), cyc: cyc + 2});
    end
    if (!rst1) begin
      if (b1.if_req_valid && b1.if_req_ready)
        exp_f1.push_back('{data: {32'h0, 32'(cyc + 4)}, cyc: cyc + 5});
      if (b1.d_req_valid && b1.d_req_ready)
        exp_d1.push_back('{data: (b1.d_req_we ? 64'h0 : {b1.d_addr[31:0], 32'(cyc + 4)}), cyc: cyc + 5});
    end
    if (b0.if_rsp_valid) obs_f0.push_back('{data: {32'h0, b0.if_rsp_data}, cyc: cyc});
    if (b0.d_rsp_valid)  obs_d0.push_back('{data: b0.d_rsp_data, cyc: cyc});
    if (b1.if_rsp_valid) obs_f1.push_back('{data: {32'h0, b1.if_rsp_data}, cyc: cyc});
    if (b1.d_rsp_valid)  obs_d1.push_back('{data: b1.d_rsp_data, cyc: cyc});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rec_t e;
    b0.if_req_valid = 1'b1; b0.if_addr = 64'h100; b0.d_req_valid = 1'b1;
    b0.d_req_we = 1'b0; b0.d_addr = 64'h200; b0.d_wdata = 64'h0;
    b1.if_req_valid = 1'b1; b1.if_addr = 64'h100; b1.d_req_valid = 1'b1;
    b1.d_req_we = 1'b0; b1.d_addr = 64'h200; b1.d_wdata = 64'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({b0.if_req_ready, b0.d_req_ready, b0.if_rsp_valid, b0.d_rsp_valid, b0.mem_en, b0.mem_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl0 got %b want 000000", {b0.if_req_ready, b0.d_req_ready, b0.if_rsp_valid, b0.d_rsp_valid, b0.mem_en, b0.mem_we});
    end
    checks++;
    if (b0.mem_addr !== 64'h0 || b0.mem_wdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_mem0 got addr %h wdata %h want 0 0", b0.mem_addr, b0.mem_wdata);
    end
    checks++;
    if (b0.if_rsp_data !== 32'h0 || b0.d_rsp_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_rspdata0 got %h %h want 0 0", b0.if_rsp_data, b0.d_rsp_data);
    end
    checks++;
    if ({b1.if_req_ready, b1.d_req_ready, b1.if_rsp_valid, b1.d_rsp_valid, b1.mem_en, b1.mem_we} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl1 got %b want 000000", {b1.if_req_ready, b1.d_req_ready, b1.if_rsp_valid, b1.d_rsp_valid, b1.mem_en, b1.mem_we});
    end
    b0.if_req_valid = 1'b0; b0.d_req_valid = 1'b0;
    b1.if_req_valid = 1'b0; b1.d_req_valid = 1'b0;
    step();
    rst0 = 1'b0; rst1 = 1'b0;
    e = '{data: 64'h0, cyc: 0};
  endtask

  task automatic test_conflict();
    logic [11:0] rf, rd, rv;
    logic acc_f, acc_d;
    int nf, nd;
    rec_t e, o;
    step();
    b0.if_req_valid = 1'b1; b0.if_addr = 64'h3000;
    b0.d_req_valid = 1'b1; b0.d_req_we = 1'b0; b0.d_addr = 64'h4000;
    nf = 0; nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      rf[k] = b0.if_req_ready; rd[k] = b0.d_req_ready; rv[k] = b0.d_rsp_valid;
      acc_f = b0.if_req_valid && b0.if_req_ready;
      acc_d = b0.d_req_valid && b0.d_req_ready;
      step();
      if (acc_f) begin nf++; if (nf == 2) b0.if_req_valid = 1'b0; else b0.if_addr = 64'h3008; end
      if (acc_d) begin nd++; if (nd == 2) b0.d_req_valid = 1'b0; else b0.d_addr = 64'h4010; end
    end
    checks++;
    if (rf[0] !== 1'b1 || rd[0] !== 1'b0) begin
      errors++; $display("FAIL conflict_first got if_rdy %b d_rdy %b want 1 0", rf[0], rd[0]);
    end
    checks++;
    if (rf[3] !== 1'b0 || rd[3] !== 1'b1) begin
      errors++; $display("FAIL conflict_second got if_rdy %b d_rdy %b want 0 1", rf[3], rd[3]);
    end
    checks++;
    if (rf[6] !== 1'b1 || rd[6] !== 1'b0) begin
      errors++; $display("FAIL conflict_third got if_rdy %b d_rdy %b want 1 0", rf[6], rd[6]);
    end
    checks++;
    if (rv !== 12'b1000_0010_0000) begin
      errors++; $display("FAIL conflict_drsp got %b want 100000100000", rv);
    end
    repeat (3) step();
    while (exp_f0.size() > 0) begin
      e = exp_f0.pop_front(); checks++;
      if (obs_f0.size() == 0) begin errors++; $display("FAIL conflict_f_sb got none want %h@%0d", e.data, e.cyc); end
      else begin
        o = obs_f0.pop_front();
        if (o.data !== e.data || o.cyc !== e.cyc) begin errors++; $display("FAIL conflict_f_sb got %h@%0d want %h@%0d", o.data, o.cyc, e.data, e.cyc); end
      end
    end
    while (exp_d0.size() > 0) begin
      e = exp_d0.pop_front(); checks++;
      if (obs_d0.size() == 0) begin errors++; $display("FAIL conflict_d_sb got none want %h@%0d", e.data, e.cyc); end
      else begin
        o = obs_d0.pop_front();
        if (o.data !== e.data || o.cyc !== e.cyc) begin errors++; $display("FAIL conflict_d_sb got %h@%0d want %h@%0d", o.data, o.cyc, e.data, e.cyc); end
      end
    end
  endtask

  task automatic test_lone_fetch();
    rec_t e, o;
    step();
    b0.if_req_valid = 1'b1; b0.if_addr = 64'h2000;
    @(negedge clk);
    checks++;
    if (b0.if_req_ready !== 1'b1) begin errors++; $display("FAIL lone_ready got %b want 1", b0.if_req_ready); end
    step();
    b0.if_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({b0.mem_en, b0.mem_we} !== 2'b10 || b0.mem_addr !== 64'h2000) begin
      errors++; $display("FAIL lone_issue got en/we %b addr %h want 10 2000", {b0.mem_en, b0.mem_we}, b0.mem_addr);
    end
    @(negedge clk);
    checks++;
    if (b0.if_rsp_valid !== 1'b1 || b0.if_rsp_data !== 32'hC840_0004) begin
      errors++; $display("FAIL lone_rsp got %b %h want 1 c8400004", b0.if_rsp_valid, b0.if_rsp_data);
    end
    repeat (2) step();
    while (exp_f0.size() > 0) begin
      e = exp_f0.pop_front(); checks++;
      if (obs_f0.size() == 0) begin errors++; $display("FAIL lone_sb got none want %h@%0d", e.data, e.cyc); end
      else begin
        o = obs_f0.pop_front();
        if (o.data !== e.data || o.cyc !== e.cyc) begin errors++; $display("FAIL lone_sb got %h@%0d want %h@%0d", o.data, o.cyc, e.data, e.cyc); end
      end
    end
  endtask

  task automatic test_store();
    int we_cnt;
    logic acc;
    logic [63:0] wa, wd;
    rec_t e, o;
    step();
    b0.d_req_valid = 1'b1; b0.d_req_we = 1'b1; b0.d_addr = 64'h80000; b0.d_wdata = 64'h1122_3344_5566_7788;
    we_cnt = 0; wa = '0; wd = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      acc = b0.d_req_valid && b0.d_req_ready;
      if (b0.mem_we === 1'b1) begin we_cnt++; wa = b0.mem_addr; wd = b0.mem_wdata; end
      step();
      if (acc) begin b0.d_req_valid = 1'b0; b0.d_req_we = 1'b0; end
    end
    checks++;
    if (we_cnt != 1) begin errors++; $display("FAIL store_we_width got %0d cycles want 1", we_cnt); end
    checks++;
    if (wa !== 64'h80000 || wd !== 64'h1122_3344_5566_7788) begin
      errors++; $display("FAIL store_bus got %h %h want 80000 1122334455667788", wa, wd);
    end
    while (exp_d0.size() > 0) begin
      e = exp_d0.pop_front(); checks++;
      if (obs_d0.size() == 0) begin errors++; $display("FAIL store_sb got none want %h@%0d", e.data, e.cyc); end
      else begin
        o = obs_d0.pop_front();
        if (o.data !== e.data || o.cyc !== e.cyc) begin errors++; $display("FAIL store_sb got %h@%0d want %h@%0d", o.data, o.cyc, e.data, e.cyc); end
      end
    end
  endtask

  task automatic test_hold();
    logic [3:0] rf;
    logic [63:0] ma;
    rec_t e, o;
    step();
    b0.d_req_valid = 1'b1; b0.d_req_we = 1'b0; b0.d_addr = 64'h5000;
    @(negedge clk); rf[0] = b0.d_req_ready;
    step();
    b0.d_req_valid = 1'b0; b0.if_req_valid = 1'b1; b0.if_addr = 64'h6000;
    @(negedge clk); rf[1] = b0.if_req_ready;
    step();
    b0.if_addr = 64'h6100;
    @(negedge clk); rf[2] = b0.if_req_ready;
    step();
    @(negedge clk); rf[3] = b0.if_req_ready;
    step();
    b0.if_req_valid = 1'b0; b0.if_addr = 64'h7000;
    @(negedge clk); ma = b0.mem_addr;
    checks++;
    if (rf !== 4'b1001) begin errors++; $display("FAIL hold_ready got %b want 1001", rf); end
    checks++;
    if (ma !== 64'h6100) begin errors++; $display("FAIL hold_addr got %h want 6100", ma); end
    repeat (3) step();
    while (exp_f0.size() > 0) begin
      e = exp_f0.pop_front(); checks++;
      if (obs_f0.size() == 0) begin errors++; $display("FAIL hold_f_sb got none want %h@%0d", e.data, e.cyc); end
      else begin
        o = obs_f0.pop_front();
        if (o.data !== e.data || o.cyc !== e.cyc) begin errors++; $display("FAIL hold_f_sb got %h@%0d want %h@%0d", o.data, o.cyc, e.data, e.cyc); end
      end
    end
    while (exp_d0.size() > 0) begin
      e = exp_d0.pop_front(); checks++;
      if (obs_d0.size() == 0) begin errors++; $display("FAIL hold_d_sb got none want %h@%0d", e.data, e.cyc); end
      else begin
        o = obs_d0.pop_front();
        if (o.data !== e.data || o.cyc !== e.cyc) begin errors++; $display("FAIL hold_d_sb got %h@%0d want %h@%0d", o.data, o.cyc, e.data, e.cyc); end
      end
    end
  endtask

  task automatic test_reset_in_issue();
    int nrsp;
    step();
    b0.d_req_valid = 1'b1; b0.d_req_we = 1'b1; b0.d_addr = 64'hB000; b0.d_wdata = 64'hCAFE;
    @(negedge clk);
    step();
    b0.d_req_valid = 1'b0; b0.d_req_we = 1'b0;
    rst0 = 1'b1;
    #1;
    checks++;
    if ({b0.mem_en, b0.mem_we} !== 2'b00 || b0.mem_addr !== 64'h0 || b0.mem_wdata !== 64'h0) begin
      errors++; $display("FAIL rst_issue_clear got en/we %b addr %h wdata %h want 00 0 0", {b0.mem_en, b0.mem_we}, b0.mem_addr, b0.mem_wdata);
    end
    repeat (2) step();
    rst0 = 1'b0;
    exp_d0.delete();
    nrsp = 0;
    repeat (6) begin @(negedge clk); if (b0.d_rsp_valid === 1'b1) nrsp++; end
    #1;
    checks++;
    if (nrsp != 0 || obs_d0.size() != 0) begin
      errors++; $display("FAIL rst_issue_norsp got %0d responses want 0", nrsp + obs_d0.size());
    end
    obs_d0.delete();
  endtask

  task automatic test_latency();
    logic [7:0] en, rv;
    logic [63:0] rdata;
    int t;
    rec_t e, o;
    step();
    b1.d_req_valid = 1'b1; b1.d_req_we = 1'b0; b1.d_addr = 64'h9000;
    t = 0; rdata = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      en[k] = b1.mem_en; rv[k] = b1.d_rsp_valid;
      if (k == 0) t = cyc;
      if (k == 5) rdata = b1.d_rsp_data;
      step();
      if (k == 0) b1.d_req_valid = 1'b0;
    end
    checks++;
    if (en !== 8'b0000_0010) begin errors++; $display("FAIL lat_mem_en got %b want 00000010", en); end
    checks++;
    if (rv !== 8'b0010_0000) begin errors++; $display("FAIL lat_rsp_valid got %b want 00100000", rv); end
    checks++;
    if (rdata !== {32'h9000, 32'(t + 4)}) begin
      errors++; $display("FAIL lat_rdata got %h want %h", rdata, {32'h9000, 32'(t + 4)});
    end
    while (exp_d1.size() > 0) begin
      e = exp_d1.pop_front(); checks++;
      if (obs_d1.size() == 0) begin errors++; $display("FAIL lat_sb got none want %h@%0d", e.data, e.cyc); end
      else begin
        o = obs_d1.pop_front();
        if (o.data !== e.data || o.cyc !== e.cyc) begin errors++; $display("FAIL lat_sb got %h@%0d want %h@%0d", o.data, o.cyc, e.data, e.cyc); end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int nrsp;
    logic got;
    rec_t e, o;
    step();
    b1.if_req_valid = 1'b1; b1.if_addr = 64'hA000;
    @(negedge clk);
    step();
    b1.if_req_valid = 1'b0;
    step();
    rst1 = 1'b1;
    #1;
    checks++;
    if ({b1.mem_en, b1.mem_we, b1.if_rsp_valid, b1.d_rsp_valid} !== 4'b0 || b1.mem_addr !== 64'h0) begin
      errors++; $display("FAIL rst_wait_clear got %b addr %h want 0000 0", {b1.mem_en, b1.mem_we, b1.if_rsp_valid, b1.d_rsp_valid}, b1.mem_addr);
    end
    repeat (2) step();
    rst1 = 1'b0;
    exp_f1.delete();
    nrsp = 0;
    repeat (8) begin @(negedge clk); if (b1.if_rsp_valid === 1'b1 || b1.d_rsp_valid === 1'b1) nrsp++; end
    #1;
    checks++;
    if (nrsp != 0 || obs_f1.size() != 0) begin
      errors++; $display("FAIL rst_wait_norsp got %0d responses want 0", nrsp + obs_f1.size());
    end
    obs_f1.delete();
    step();
    b1.if_req_valid = 1'b1; b1.if_addr = 64'hA100;
    b1.d_req_valid = 1'b1; b1.d_req_we = 1'b0; b1.d_addr = 64'hA200;
    @(negedge clk);
    checks++;
    if (b1.if_req_ready !== 1'b1 || b1.d_req_ready !== 1'b0) begin
      errors++; $display("FAIL rst_wait_tie got if_rdy %b d_rdy %b want 1 0", b1.if_req_ready, b1.d_req_ready);
    end
    step();
    b1.if_req_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(negedge clk);
      got = b1.d_req_valid && b1.d_req_ready;
      step();
    end
    b1.d_req_valid = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL rst_wait_data_accept got no accept want accept within 12 cycles"); end
    repeat (8) step();
    while (exp_f1.size() > 0) begin
      e = exp_f1.pop_front(); checks++;
      if (obs_f1.size() == 0) begin errors++; $display("FAIL rst_wait_f_sb got none want %h@%0d", e.data, e.cyc); end
      else begin
        o = obs_f1.pop_front();
        if (o.data !== e.data || o.cyc !== e.cyc) begin errors++; $display("FAIL rst_wait_f_sb got %h@%0d want %h@%0d", o.data, o.cyc, e.data, e.cyc); end
      end
    end
    while (exp_d1.size() > 0) begin
      e = exp_d1.pop_front(); checks++;
      if (obs_d1.size() == 0) begin errors++; $display("FAIL rst_wait_d_sb got none want %h@%0d", e.data, e.cyc); end
      else begin
        o = obs_d1.pop_front();
        if (o.data !== e.data || o.cyc !== e.cyc) begin errors++; $display("FAIL rst_wait_d_sb got %h@%0d want %h@%0d", o.data, o.cyc, e.data, e.cyc); end
      end
    end
  endtask

  task automatic test_leftovers();
    int n;
    n = obs_f0.size() + obs_d0.size() + obs_f1.size() + obs_d1.size();
    checks++;
    if (n != 0) begin errors++; $display("FAIL leftover_rsp got %0d unmatched responses want 0", n); end
  endtask

  initial begin
    b0.if_req_valid = 1'b0; b0.if_addr = '0; b0.d_req_valid = 1'b0;
    b0.d_req_we = 1'b0; b0.d_addr = '0; b0.d_wdata = '0;
    b1.if_req_valid = 1'b0; b1.if_addr = '0; b1.d_req_valid = 1'b0;
    b1.d_req_we = 1'b0; b1.d_addr = '0; b1.d_wdata = '0;
    test_reset();
    test_conflict();
    test_lone_fetch();
    test_store();
    test_hold();
    test_reset_in_issue();
    test_latency();
    test_reset_mid_wait();
    test_leftovers();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tinker_mem_arbiter.md
# tinker_mem_arbiter

Shares the single-port Tinker byte memory between the instruction-fetch path and the load/store (data) path of the core. Accepts one request at a time from either requester over a valid/ready handshake, arbitrates round-robin on conflicts, and sequences the memory access. Returns read data or a write acknowledgement to the winning requester after a fixed, parameterised memory latency. Sits between the core FSM and the memory unit; the memory unit sees exactly one requester.

## Interface
- MEM_LATENCY, 0: cycles from the issue cycle until `mem_rdata` is valid; legal range 0..7. 0 means combinational read.
- ADDR_W, 64: address width.

- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDR_W  fetch byte address
- if_rsp_valid  out  1  fetch response, one-cycle pulse
- if_rsp_data  out  32  instruction word = captured `mem_rdata[31:0]`
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_req_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  64  store data
- d_rsp_valid  out  1  data response or store acknowledgement, one-cycle pulse
- d_rsp_data  out  64  load data; 0 for stores
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  memory read data, little-endian

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - `*_req_ready` is asserted only in IDLE, for the granted requester only.
  - Ready may depend combinationally on valid. Valid must never depend on ready.
  - On an accept (valid && ready), register the grant, address, we and wdata, then go to ISSUE.
  - Fetch requests are always reads (`we` = 0).
- Arbitration:
  - One requester valid: it wins.
  - Both valid: the requester not granted last time wins.
  - `last_grant` resets to DATA, so fetch wins the first tie.
  - `last_grant` updates only on an accept.
- ISSUE (one cycle):
  - `mem_en` = 1; `mem_we` = registered we; `mem_addr` and `mem_wdata` are the registered values.
  - If MEM_LATENCY = 0, capture `mem_rdata` and go to RESP. Otherwise load the latency counter with MEM_LATENCY−1 and go to WAIT.
- WAIT:
  - `mem_en` = 0.
  - The counter decrements each cycle. When the counter is 0, capture `mem_rdata` and go to RESP.
- RESP (one cycle):
  - Assert `if_rsp_valid` or `d_rsp_valid` for the granted requester, then go to IDLE.
  - Responses have no backpressure.
- Stores return `d_rsp_data` = 0. Fetch returns the low 32 bits of the captured word.
- Addresses pass through unmodified. There is no alignment check or wrap handling; wrap and bounds are the memory's responsibility.
- Requester rule: once valid is asserted, the requester holds valid and the payload until accepted. Dropping valid early is a protocol violation and the behaviour is undefined.
- At most one transaction is in flight. Requests arriving outside IDLE wait.

## Timing
- Reset values: all outputs 0; internal address, data and capture registers 0; `last_grant` = DATA; state IDLE.
- Reset asserted mid-transaction:
  - Outputs clear immediately and asynchronously, including `mem_en` and `mem_we`.
  - The in-flight response is discarded.
- Per-transaction timing, with accept in cycle T and L = MEM_LATENCY:
  - ISSUE is cycle T+1.
  - `mem_rdata` is sampled at the end of cycle T+1+L.
  - `rsp_valid` is high in cycle T+2+L.
  - The next accept can occur no earlier than cycle T+3+L.
- Throughput: one transaction per L+3 cycles.
- Strobe widths: `mem_en` is exactly one cycle per transaction. `mem_we` is high only in the ISSUE cycle of a store.
- Response outputs are registered. There is no combinational path from `mem_rdata` to `*_rsp_*`.

## Structure
- Package `tinker_arb_pkg`:
  - `arb_state_t` enum: IDLE, ISSUE, WAIT, RESP.
  - `arb_grant_t` enum: FETCH, DATA.
  - Constant `ARB_MAX_LATENCY` = 7.
- Sub-module `tinker_rr_arb2`: two-input round-robin picker.
  - Inputs: `req[1:0]`, `last_grant`, enable.
  - Output: one-hot grant.
  - Purely combinational; `last_grant` stays in the parent.
- Latency counter: 3 bits.

## Test plan
- **Lone fetch:** L=0, `if_addr`=0x2000, memory word 0x00000000_C8400004 → `if_req_ready` in T, `mem_en` in T+1, `if_rsp_valid` in T+2 with `if_rsp_data`=0xC8400004.
- **Conflict:** both valid at T → fetch granted first. Data is granted at T+3 and `d_rsp_valid` is in T+5. With both still requesting, fetch is granted at T+6.
- **Store:** `d_req_we`=1, `d_addr`=0x80000, `d_wdata`=0x1122334455667788 → `mem_we`=1 for exactly one cycle with that address and data, then `d_rsp_valid` with `d_rsp_data`=0.
- **Latency:** L=3 load at T → `rsp_valid` in T+5 only. `d_rsp_data` equals `mem_rdata` at T+4, not at T+1..T+3.
- **Reset mid-WAIT:** L=3, assert reset at T+2 → `mem_en`, `mem_we` and `rsp_valid` are 0 immediately. No response follows. Fetch wins the first tie after reset.
- **Held request:** fetch held valid while data is in flight → ready stays 0 until IDLE. The fetch address is sampled only at accept, even if the bench changes it illegally.
